// File: rtl/pc_pkg.sv
// ============================================================================
// pc_pkg : shared types, default parameters and alignment helper for pc_gen
// Revision: 1.0
// ============================================================================
`default_nettype none

package pc_pkg;

   typedef enum logic [0:0] {
      PC_HOLD = 1'b0,
      PC_RUN  = 1'b1
   } pc_state_e;

   localparam int unsigned PC_XLEN      = 32;
   localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] PC_TRAP_VEC  = 32'h0000_0100;

   // Mask that clears the byte-offset bits below one instruction.
   function automatic logic [63:0] align_mask(input int unsigned instr_bytes);
      logic [63:0] step;
      step       = 64'(instr_bytes);
      align_mask = ~(step - 64'd1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_boot_hold.sv
// ============================================================================
// pc_boot_hold : 4-bit post-reset down-counter, done when it reaches zero
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_boot_hold #(
   parameter int unsigned BOOT_HOLD = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic done
);

   logic [3:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 4'(BOOT_HOLD);
      end else if (en && (count != 4'd0)) begin
         count <= count - 4'd1;
      end
   end

   assign done = (count == 4'd0);

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// pc_gen : fetch program-counter generator with boot hold, stall and redirect
//          Optional misaligned-redirect trap enabled by PC_MISALIGN_TRAP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_gen
   import pc_pkg::*;
#(
   parameter int unsigned      XLEN        = PC_XLEN,
   parameter logic [XLEN-1:0]  RESET_VEC   = PC_RESET_VEC,
   parameter logic [XLEN-1:0]  TRAP_VEC    = PC_TRAP_VEC,
   parameter int unsigned      INSTR_BYTES = 4,
   parameter int unsigned      BOOT_HOLD   = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] pc,
`ifdef PC_MISALIGN_TRAP_EN
   output logic            misalign_trap,
   output logic [XLEN-1:0] trap_addr,
`endif
   output logic            pc_valid
);

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(INSTR_BYTES));
   localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);

   pc_state_e state;
   logic      boot_done;
   logic      hold_en;

   assign hold_en = (state == PC_HOLD);

   pc_boot_hold #(
      .BOOT_HOLD (BOOT_HOLD)
   ) u_boot_hold (
      .clk  (clk),
      .rst  (rst),
      .en   (hold_en),
      .done (boot_done)
   );

`ifdef PC_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = |(redirect_pc & ~ALIGN_MASK);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= PC_HOLD;
         pc       <= RESET_VEC;
         pc_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
         misalign_trap <= 1'b0;
         trap_addr     <= '0;
`endif
      end else begin
`ifdef PC_MISALIGN_TRAP_EN
         misalign_trap <= 1'b0;
`endif
         case (state)
            PC_HOLD: begin
               // Stall and redirect are deliberately ignored until boot hold ends.
               pc <= RESET_VEC;
               if (boot_done) begin
                  state    <= PC_RUN;
                  pc_valid <= 1'b1;
               end
            end
            PC_RUN: begin
               pc_valid <= 1'b1;
               if (redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
                  if (misaligned) begin
                     pc            <= TRAP_VEC;
                     trap_addr     <= redirect_pc;
                     misalign_trap <= 1'b1;
                  end else begin
                     pc <= redirect_pc & ALIGN_MASK;
                  end
`else
                  pc <= redirect_pc & ALIGN_MASK;
`endif
               end else if (!stall) begin
                  pc <= pc + STEP;
               end
            end
            default: begin
               state    <= PC_HOLD;
               pc       <= RESET_VEC;
               pc_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
